// File: rtl/game_step_timer.sv
// game_step_timer: paces the game by turning 1 ms ticks into Step pulses.
// Every SPEEDUP_EVERY steps the period shrinks by STEP_DEC ms, floored at MIN_PERIOD.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset/Restart; waits for Enable, ticks ignored
// RUN    | counting ticks while Enable stays high
// PAUSED | Enable dropped; counters, period and level frozen
module game_step_timer #(
    parameter int PERIOD_W      = 10,
    parameter int START_PERIOD  = 500,
    parameter int MIN_PERIOD    = 100,
    parameter int STEP_DEC      = 25,
    parameter int SPEEDUP_EVERY = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Enable,
    input  logic                Restart,
    input  logic                Tick,
    output logic                Step,
    output logic [PERIOD_W-1:0] Period,
    output logic [3:0]          Level,
    output logic                AtMax
);

    localparam int SC_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY) : 1;

    localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] P_ONE   = PERIOD_W'(1);
    localparam logic [PERIOD_W:0]   DEC_EXT = (PERIOD_W+1)'(STEP_DEC);
    localparam logic [SC_W-1:0]     SC_LAST = SC_W'(SPEEDUP_EVERY - 1);
    localparam logic [SC_W-1:0]     SC_ONE  = SC_W'(1);
    localparam logic                AT_MAX_RST = (START_P == MIN_P);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [PERIOD_W-1:0] ms_cnt, ms_nxt;
    logic [SC_W-1:0]     step_cnt, sc_nxt;
    logic [PERIOD_W-1:0] period_nxt;
    logic [3:0]          level_nxt;
    logic                step_nxt;
    logic [PERIOD_W:0]   period_diff;
    logic [PERIOD_W-1:0] period_dec;

    // Shrunk period, computed one bit wider so an underflow shows up as a set MSB.
    always_comb begin
        period_diff = {1'b0, Period} - DEC_EXT;
        if (period_diff[PERIOD_W] || (period_diff < {1'b0, MIN_P}))
            period_dec = MIN_P;
        else
            period_dec = period_diff[PERIOD_W-1:0];
    end

    // Next-state and next-datapath logic; Restart overrides everything.
    always_comb begin
        state_nxt  = state;
        ms_nxt     = ms_cnt;
        sc_nxt     = step_cnt;
        period_nxt = Period;
        level_nxt  = Level;
        step_nxt   = 1'b0;
        if (Restart) begin
            state_nxt  = IDLE;
            ms_nxt     = '0;
            sc_nxt     = '0;
            period_nxt = START_P;
            level_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Enable) state_nxt = RUN;
                end
                RUN: begin
                    if (!Enable) begin
                        state_nxt = PAUSED;
                    end else if (Tick) begin
                        if (ms_cnt == Period - P_ONE) begin
                            ms_nxt   = '0;
                            step_nxt = 1'b1;
                            if (step_cnt == SC_LAST) begin
                                sc_nxt     = '0;
                                period_nxt = period_dec;
                                if (Level != 4'hF) level_nxt = Level + 4'd1;
                            end else begin
                                sc_nxt = step_cnt + SC_ONE;
                            end
                        end else begin
                            ms_nxt = ms_cnt + P_ONE;
                        end
                    end
                end
                PAUSED: begin
                    if (Enable) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and datapath registers; AtMax tracks the period being loaded.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            ms_cnt   <= '0;
            step_cnt <= '0;
            Step     <= 1'b0;
            Period   <= START_P;
            Level    <= '0;
            AtMax    <= AT_MAX_RST;
        end else begin
            state    <= state_nxt;
            ms_cnt   <= ms_nxt;
            step_cnt <= sc_nxt;
            Step     <= step_nxt;
            Period   <= period_nxt;
            Level    <= level_nxt;
            AtMax    <= (period_nxt == MIN_P);
        end
    end

endmodule
